// File: rtl/hilo_mult_sequencer.sv
// HI/LO shift-add multiplier (mult/multu, madd/msub when MULT_ACCUM_EN is defined) with mthi/mtlo moves.
// Latency: 34 edges from the launch edge to the Done pulse; Hi/Lo update on the final edge.
// Backpressure: Start and moves are ignored while Busy; nothing is queued.
`timescale 1ns/1ps

module hilo_mult_sequencer (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MoveHi,
    input  logic        MoveLo,
    input  logic [31:0] MoveData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic        sign_q;
    logic [63:0] acc_q;
    logic [4:0]  cnt_q;
    logic [63:0] prod;
    logic [63:0] hilo_nxt;

`ifdef MULT_ACCUM_EN
    logic        accum_q;
    logic        sub_q;

    assign signed_op = (Op != 2'b01);
`else
    // Op[1] has no meaning in this build: 10 behaves as mult, 11 as multu.
    logic        unused_op;

    assign unused_op = Op[1];
    assign signed_op = ~Op[0];
`endif

    // Two's-complement negation also maps 0x80000000 onto itself, which is the correct magnitude.
    assign a_mag = (signed_op && A[31]) ? (~A + 32'd1) : A;
    assign b_mag = (signed_op && B[31]) ? (~B + 32'd1) : B;

    assign prod = sign_q ? (~acc_q + 64'd1) : acc_q;

`ifdef MULT_ACCUM_EN
    assign hilo_nxt = !accum_q ? prod :
                      sub_q    ? ({Hi, Lo} - prod) : ({Hi, Lo} + prod);
`else
    assign hilo_nxt = prod;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (cnt_q == 5'd31) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            sign_q   <= 1'b0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Hi       <= 32'd0;
            Lo       <= 32'd0;
`ifdef MULT_ACCUM_EN
            accum_q  <= 1'b0;
            sub_q    <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (MoveHi) Hi <= MoveData;
                    if (MoveLo) Lo <= MoveData;
                    if (Start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        sign_q   <= signed_op & (A[31] ^ B[31]);
                        acc_q    <= 64'd0;
                        cnt_q    <= 5'd0;
                        Busy     <= 1'b1;
`ifdef MULT_ACCUM_EN
                        accum_q  <= Op[1];
                        sub_q    <= Op[1] & Op[0];
`endif
                    end
                end
                RUN: begin
                    if (mplier_q[cnt_q]) acc_q <= acc_q + ({32'd0, mcand_q} << cnt_q);
                    cnt_q <= cnt_q + 5'd1;
                end
                FIN: begin
                    {Hi, Lo} <= hilo_nxt;
                    Busy     <= 1'b0;
                    Done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Randomised + directed bench for hilo_mult_sequencer against a transaction-level HI/LO model.
// Define MULT_ACCUM_EN for both bench and RTL to exercise madd/msub.
`timescale 1ns/1ps

module tb_hilo_mult_sequencer;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        MoveHi;
    logic        MoveLo;
    logic [31:0] MoveData;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    hilo_mult_sequencer dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .MoveHi   (MoveHi),
        .MoveLo   (MoveLo),
        .MoveData (MoveData),
        .Busy     (Busy),
        .Done     (Done),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural result of an operation, from plain 64-bit arithmetic.
    function automatic logic [63:0] op_result(input logic [63:0] hilo, input logic [1:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        bit                 sgn;
        bit                 acc;
        bit                 sub;
`ifdef MULT_ACCUM_EN
        sgn = (op != 2'b01);
        acc = op[1];
        sub = op[1] & op[0];
`else
        sgn = !op[0];
        acc = 0;
        sub = 0;
`endif
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            p  = sa * sb;
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        if (!acc) return p;
        return sub ? (hilo - p) : (hilo + p);
    endfunction

    // Model: an accepted launch completes 33 edges later; moves only land while idle.
    logic        m_busy = 0;
    logic        m_done = 0;
    logic [63:0] m_hilo = 0;
    int          m_left = 0;
    logic [1:0]  m_op = 0;
    logic [31:0] m_a = 0;
    logic [31:0] m_b = 0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_busy <= 0;
            m_done <= 0;
            m_hilo <= 64'd0;
            m_left <= 0;
        end else begin
            m_done <= 0;
            if (!m_busy) begin
                if (MoveHi) m_hilo[63:32] <= MoveData;
                if (MoveLo) m_hilo[31:0]  <= MoveData;
                if (Start) begin
                    m_a    <= A;
                    m_b    <= B;
                    m_op   <= Op;
                    m_busy <= 1;
                    m_left <= 33;
                end
            end else if (m_left == 1) begin
                m_busy <= 0;
                m_done <= 1;
                m_hilo <= op_result(m_hilo, m_op, m_a, m_b);
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("busy", 64'(Busy), 64'(m_busy));
            chk("done", 64'(Done), 64'(m_done));
            chk("hi",   64'(Hi),   m_hilo[63:32]);
            chk("lo",   64'(Lo),   m_hilo[31:0]);
        end
    end

    // Caller must be at a falling edge. Returns edges from launch until Done is seen, or -1 if reset.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mh, input logic ml, input logic [31:0] md,
                          input int glitch_at, input int rst_at, output int n);
        bit got;
        Op = op; A = a; B = b;
        MoveHi = mh; MoveLo = ml; MoveData = md;
        Start = 1'b1;
        n = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            Start = 1'b0; MoveHi = 1'b0; MoveLo = 1'b0;
            if (n == rst_at) begin
                #1 Rst = 1'b1;
                @(negedge Clk);
                #1 Rst = 1'b0;
                n = -1;
                return;
            end
            if (n == glitch_at) begin
                Start = 1'b1; MoveHi = 1'b1; MoveLo = 1'b1;
                MoveData = $urandom;
                A = $urandom; B = $urandom; Op = 2'($urandom);
            end
            if (Done) got = 1;
        end
        Start = 1'b0; MoveHi = 1'b0; MoveLo = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h8000_0000;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h7FFF_FFFF;
        corners[4] = 32'h0000_0001;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int n;
        Rst = 1'b1;
        Start = 0; Op = 0; A = 0; B = 0;
        MoveHi = 0; MoveLo = 0; MoveData = 0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_hi",   64'(Hi),   64'd0);
        chk("rst_lo",   64'(Lo),   64'd0);
        cmp_en = 1;
        #1 Rst = 1'b0;
        @(negedge Clk);

        // -3 * 7
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, -1, -1, n);
        chk("lat_first", 64'(n), 64'd34);
        chk("neg3x7", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Back-to-back: launched in the Done cycle.
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, -1, -1, n);
        chk("lat_b2b", 64'(n), 64'd34);
        chk("multu_ff", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, -1, -1, n);
        chk("mult_ff", {Hi, Lo}, 64'h0000_0000_0000_0001);

        // Start, moves and operand changes during RUN must all be ignored.
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 11, -1, n);
        chk("lat_glitch", 64'(n), 64'd34);
        chk("min_sq", {Hi, Lo}, 64'h4000_0000_0000_0000);
        @(negedge Clk);
        chk("single_done", 64'(Done), 64'd0);
        chk("idle_after", 64'(Busy), 64'd0);

        run_op(2'b10, 32'd2, 32'd3, 1, 1, 32'd5, -1, -1, n);
`ifdef MULT_ACCUM_EN
        chk("madd_move", {Hi, Lo}, 64'h0000_0005_0000_000B);
`else
        chk("madd_move", {Hi, Lo}, 64'h0000_0000_0000_0006);
`endif

        // Clear Hi/Lo so the abort check below sees zeros.
        run_op(2'b01, 32'd0, 32'd0, 0, 0, 0, -1, -1, n);
        run_op(2'b00, 32'd9, 32'd9, 0, 0, 0, -1, 17, n);
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_hilo", {Hi, Lo}, 64'd0);
        run_op(2'b00, 32'd9, 32'd9, 0, 0, 0, -1, -1, n);
        chk("lat_after_rst", 64'(n), 64'd34);
        chk("nine_sq", {Hi, Lo}, 64'd81);

        for (int it = 0; it < 50; it++) begin
            int g;
            int r;
            if ($urandom_range(0, 3) == 0) begin
                MoveHi = 1'($urandom); MoveLo = 1'($urandom); MoveData = $urandom;
                @(negedge Clk);
                MoveHi = 0; MoveLo = 0;
                repeat ($urandom_range(0, 2)) @(negedge Clk);
            end
            g = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(2, 32));
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 33)) : -1;
            run_op(2'($urandom), pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
                   $urandom, g, r, n);
            if (r < 0) chk("lat_rand", 64'(n), 64'd34);
        end

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
